jtag_result_tx: RTL and testbench
=================================

# jtag_result_tx

Return path from the puzzle solver to the host over the JTAG user data register. It accepts one result word from the solver through a valid/ready handshake and holds it. It loads that word plus a status header into a shift register on Capture-DR, and shifts it out on `tdo` during Shift-DR. The host acknowledges a complete read on Update-DR, which frees the holding register for the next result. The block sits beside the input deserializer on the same TAP-state signals, running entirely in the `tck` domain.

## Interface
- `RESULT_WIDTH`, default 32: width of the solver result word.
- `FRAME_WIDTH`, fixed at RESULT_WIDTH+8: number of bits in one DR frame (8-bit header plus result).
- `tck` input 1: sole clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low; clears all state.
- `tdi` input 1: serial data in; shifted into the frame MSB while shifting; content is ignored.
- `tdo` output 1: serial data out, equal to `shreg[0]`.
- `test_logic_reset` input 1: TAP in Test-Logic-Reset; clears the shift path only.
- `ir_is_user` input 1: the user DR is selected; qualifies all capture, shift and update actions.
- `capture_dr` input 1: TAP in Capture-DR.
- `shift_dr` input 1: TAP in Shift-DR.
- `update_dr` input 1: TAP in Update-DR.
- `result_valid` input 1: the solver offers `result_data`.
- `result_data` input RESULT_WIDTH: result word.
- `result_ready` output 1: the block can accept a result; equals `!hold_valid`.

## Operation
- Holding register: `hold_data`, `hold_valid`.
  - On `result_valid && result_ready`: `hold_data <= result_data`, `hold_valid <= 1`.
  - `result_ready` falls the cycle after acceptance.
- Header byte, LSB first on the wire:
  - bit0 = `hold_valid` at capture.
  - bits3:1 = 0.
  - bits7:4 = `seq`, the count of acknowledged results mod 16.
- Frame layout: `{hold_data, header}`. `tdo` emits header bit0 first and the result MSB last.
- Shift-path state machine:
  - States: IDLE, LOADED, SHIFTING.
  - Capture (`capture_dr && ir_is_user`), from any state:
    - `shreg <= frame`, `bitcnt <= 0`.
    - `cap_valid <= hold_valid`.
    - Go to LOADED.
  - Shift (`shift_dr && ir_is_user`) in LOADED or SHIFTING:
    - `shreg <= {tdi, shreg[FRAME_WIDTH-1:1]}`.
    - `bitcnt` increments and saturates at FRAME_WIDTH.
    - Go to SHIFTING.
  - Update (`update_dr && ir_is_user`) in LOADED or SHIFTING:
    - Ack when `cap_valid && bitcnt == FRAME_WIDTH`: `hold_valid <= 0` and `seq <= seq+1` (4-bit wrap).
    - Return to IDLE in all cases.
  - Shift or update in IDLE: no effect.
- Boundary rules:
  - Partial read (`bitcnt < FRAME_WIDTH` at update): no ack. The held result survives and is re-sent on the next capture.
  - Over-shift (more than FRAME_WIDTH shift cycles): `bitcnt` stays saturated and `tdo` delivers the `tdi` bits shifted in earlier. The ack still occurs.
  - Result accepted between capture and update: `cap_valid` is 0, so there is no ack. The new result is kept and sent in the next frame.
  - Capture with `hold_valid = 0`: the frame carries a valid bit of 0 and stale `hold_data`. The host must ignore the data.
  - Acceptance and ack can never coincide, because `result_ready` is 0 while holding. After an ack, `result_ready` is 1 on the next cycle.
  - `ir_is_user = 0`: capture, shift and update are all ignored. `tdo` still reflects `shreg[0]`.
- `test_logic_reset = 1`:
  - Clears: shift-path state to IDLE, `shreg`, `bitcnt`, `cap_valid`.
  - Keeps: `hold_*` and `seq`.
- `rst_n = 0` (including mid-shift):
  - Clears: `hold_valid`, `hold_data`, `seq`, `shreg`, `bitcnt`, `cap_valid`; state goes to IDLE.
  - It takes priority over every other event.

## Timing
- Reset values: `tdo = 0`, `result_ready = 1`.
- Capture-to-first-bit: the header bit0 is on `tdo` in the cycle after the capture edge, which is the first Shift-DR cycle.
- Each shift edge advances `tdo` by one bit. After k shifts, `tdo` shows frame bit k.
- Accept-to-visible: one cycle. A capture on the cycle after acceptance sees `hold_valid = 1`.
- Ack-to-ready: one cycle after the Update-DR edge.
- No combinational path from the TAP inputs to `tdo`.

## Test plan
- Accept-and-read:
  - Stimulus: reset, then offer `result_data = 0x0000_1F4A`, then capture and shift 40 bits.
  - Required: `tdo` gives header 0x01 then 0x1F4A, LSB first.
  - Required after update: `result_ready = 1`, and the next frame header reads 0x10.
- Empty read: capture with nothing held and shift 40 bits → header 0x00, no ack, `seq` unchanged.
- Partial read:
  - Stimulus: a result is held; shift 20 bits, then update.
  - Required: `result_ready` stays 0; the next full read again shows header 0x01 and the same data, then is acked.
- Late arrival: capture with nothing held, accept result 0x5 before update, then update → no ack; the next frame shows valid=1 and data 0x5.
- Sequence wrap: 17 acked reads → header bits7:4 read 0x0 then 0x1.
- Reset mid-operation:
  - `rst_n` low for one cycle at shift bit 10: `tdo = 0`, `result_ready = 1`, `seq = 0`, and the following update has no effect.
  - `test_logic_reset` at shift bit 10 instead: the held result is kept and the next full read returns it.

Source files
------------

// File: rtl/jtag_result_tx.sv
// -----------------------------------------------------------------------------
// jtag_result_tx
// Return path from the puzzle solver to the host through the JTAG user DR.
// The block takes one result word from the solver over a valid/ready handshake
// and keeps it in a holding register. On Capture-DR it loads a frame of
// {result, header} into a shift register. During Shift-DR it sends that frame
// out on tdo, LSB first. An Update-DR that follows a complete read acknowledges
// the result, which frees the holding register and advances the sequence
// count. Everything runs in the tck domain.
//
// Ports:
//   tck               sole clock (rising edge)
//   rst_n             synchronous active-low reset, clears all state
//   tdi               serial in, shifted into the frame MSB (content ignored)
//   tdo               serial out, shreg[0]
//   test_logic_reset  TAP Test-Logic-Reset, clears the shift path only
//   ir_is_user        user DR selected, qualifies capture/shift/update
//   capture_dr        TAP Capture-DR
//   shift_dr          TAP Shift-DR
//   update_dr         TAP Update-DR
//   result_valid      solver offers result_data
//   result_data       solver result word
//   result_ready      holding register empty (!hold_valid)
// -----------------------------------------------------------------------------
module jtag_result_tx #(
   parameter int RESULT_WIDTH = 32
) (
   input  logic                    tck,
   input  logic                    rst_n,
   input  logic                    tdi,
   output logic                    tdo,
   input  logic                    test_logic_reset,
   input  logic                    ir_is_user,
   input  logic                    capture_dr,
   input  logic                    shift_dr,
   input  logic                    update_dr,
   input  logic                    result_valid,
   input  logic [RESULT_WIDTH-1:0] result_data,
   output logic                    result_ready
);

   localparam int FRAME_WIDTH = RESULT_WIDTH + 8;
   localparam int CNT_W       = $clog2(FRAME_WIDTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      LOADED,
      SHIFTING
   } state_t;

   state_t                  state;
   logic [FRAME_WIDTH-1:0]  shreg;
   logic [CNT_W-1:0]        bitcnt;
   logic                    cap_valid;
   logic [RESULT_WIDTH-1:0] hold_data;
   logic                    hold_valid;
   logic [3:0]              seq;

   logic                    accept;
   logic                    do_capture;
   logic                    do_shift;
   logic                    do_update;
   logic                    ack;
   logic [FRAME_WIDTH-1:0]  frame;

   assign accept     = result_valid && !hold_valid;
   assign do_capture = capture_dr && ir_is_user;
   assign do_shift   = shift_dr && ir_is_user && (state != IDLE);
   assign do_update  = update_dr && ir_is_user && (state != IDLE);

   // Only a frame that captured a valid result and was shifted out completely
   // counts as a read. A TAP reset on the same edge wins over the update.
   assign ack = do_update && !test_logic_reset && !do_capture && !do_shift &&
                cap_valid && (bitcnt == FULL_CNT);

   // Header: bit0 valid flag, bits3:1 zero, bits7:4 sequence count.
   assign frame = {hold_data, seq, 3'b000, hold_valid};

   assign tdo          = shreg[0];
   assign result_ready = !hold_valid;

   always_ff @(posedge tck) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         cap_valid  <= 1'b0;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         seq        <= 4'd0;
      end else begin
         // Holding register: acceptance and ack are exclusive because
         // result_ready is low whenever an ack is possible.
         if (accept) begin
            hold_data  <= result_data;
            hold_valid <= 1'b1;
         end else if (ack) begin
            hold_valid <= 1'b0;
            seq        <= seq + 4'd1;
         end

         // Shift path
         if (test_logic_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            cap_valid <= 1'b0;
         end else if (do_capture) begin
            shreg     <= frame;
            bitcnt    <= '0;
            cap_valid <= hold_valid;
            state     <= LOADED;
         end else if (do_shift) begin
            shreg <= {tdi, shreg[FRAME_WIDTH-1:1]};
            if (bitcnt != FULL_CNT) begin
               bitcnt <= bitcnt + 1'b1;
            end
            state <= SHIFTING;
         end else if (do_update) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_jtag_result_tx.sv
module tb_jtag_result_tx;

   logic        tck = 1'b0;
   logic        rst_n = 1'b0;
   logic        tdi = 1'b0;
   logic        tdo;
   logic        test_logic_reset = 1'b0;
   logic        ir_is_user = 1'b1;
   logic        capture_dr = 1'b0;
   logic        shift_dr = 1'b0;
   logic        update_dr = 1'b0;
   logic        result_valid = 1'b0;
   logic [31:0] result_data = '0;
   logic        result_ready;

   int checks = 0;
   int passed = 0;

   jtag_result_tx #(.RESULT_WIDTH(32)) dut (
      .tck              (tck),
      .rst_n            (rst_n),
      .tdi              (tdi),
      .tdo              (tdo),
      .test_logic_reset (test_logic_reset),
      .ir_is_user       (ir_is_user),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .result_valid     (result_valid),
      .result_data      (result_data),
      .result_ready     (result_ready)
   );

   always #5 tck = ~tck;

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   function automatic logic pat(input int k);
      return (k % 3) == 0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic offer(input logic [31:0] d);
      result_data  = d;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
   endtask

   task automatic capture();
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
   endtask

   // Samples tdo before each shift edge: got[k] is tdo after k shifts.
   task automatic shift_n(input int n, output logic [79:0] got);
      got = '0;
      for (int k = 0; k < n; k++) begin
         got[k]   = tdo;
         tdi      = pat(k);
         shift_dr = 1'b1;
         tick();
      end
      shift_dr = 1'b0;
      tdi      = 1'b0;
   endtask

   task automatic update();
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
   endtask

   task automatic read_frame(output logic [79:0] got);
      capture();
      shift_n(40, got);
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      checks++;
      if (tdo !== 1'b0) $display("FAIL reset_tdo: got %b want 0", tdo);
      else passed++;
      checks++;
      if (result_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", result_ready);
      else passed++;
   endtask

   task automatic test_accept_and_read();
      logic [79:0] got;
      offer(32'h0000_1F4A);
      checks++;
      if (result_ready !== 1'b0) $display("FAIL accept_ready_low: got %b want 0", result_ready);
      else passed++;
      read_frame(got);
      checks++;
      if (got[39:0] !== {32'h0000_1F4A, 8'h01})
         $display("FAIL accept_frame: got %h want %h", got[39:0], {32'h0000_1F4A, 8'h01});
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b1) $display("FAIL ack_ready: got %b want 1", result_ready);
      else passed++;
   endtask

   task automatic test_empty_read();
      logic [79:0] got;
      read_frame(got);
      checks++;
      if (got[39:0] !== {32'h0000_1F4A, 8'h10})
         $display("FAIL empty_frame1: got %h want %h", got[39:0], {32'h0000_1F4A, 8'h10});
      else passed++;
      update();
      read_frame(got);
      update();
      checks++;
      if (got[7:0] !== 8'h10) $display("FAIL empty_seq_kept: got %h want 10", got[7:0]);
      else passed++;
   endtask

   task automatic test_partial_read();
      logic [79:0] got;
      offer(32'hABCD_1234);
      capture();
      shift_n(20, got);
      update();
      checks++;
      if (result_ready !== 1'b0) $display("FAIL partial_no_ack: got %b want 0", result_ready);
      else passed++;
      read_frame(got);
      checks++;
      if (got[39:0] !== {32'hABCD_1234, 8'h11})
         $display("FAIL partial_resend: got %h want %h", got[39:0], {32'hABCD_1234, 8'h11});
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b1) $display("FAIL partial_final_ack: got %b want 1", result_ready);
      else passed++;
   endtask

   task automatic test_late_arrival();
      logic [79:0] got;
      capture();
      offer(32'h0000_0005);
      shift_n(40, got);
      checks++;
      if (got[39:0] !== {32'hABCD_1234, 8'h20})
         $display("FAIL late_frame: got %h want %h", got[39:0], {32'hABCD_1234, 8'h20});
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b0) $display("FAIL late_no_ack: got %b want 0", result_ready);
      else passed++;
      read_frame(got);
      checks++;
      if (got[39:0] !== {32'h0000_0005, 8'h21})
         $display("FAIL late_next_frame: got %h want %h", got[39:0], {32'h0000_0005, 8'h21});
      else passed++;
      update();
   endtask

   task automatic test_seq_wrap();
      logic [79:0] got;
      logic [7:0]  hdr;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         offer(32'h1000_0000 + i);
         read_frame(got);
         update();
         hdr = {4'(i), 4'b0001};
         checks++;
         if (got[39:0] !== {32'h1000_0000 + i, hdr})
            $display("FAIL wrap_read_%0d: got %h want %h", i, got[39:0], {32'h1000_0000 + i, hdr});
         else passed++;
      end
      read_frame(got);
      update();
      checks++;
      if (got[7:0] !== 8'h10) $display("FAIL wrap_after17: got %h want 10", got[7:0]);
      else passed++;
   endtask

   task automatic test_overshift();
      logic [79:0] got;
      offer(32'hCAFE_F00D);
      capture();
      shift_n(43, got);
      checks++;
      if (got[39:0] !== {32'hCAFE_F00D, 8'h11})
         $display("FAIL over_frame: got %h want %h", got[39:0], {32'hCAFE_F00D, 8'h11});
      else passed++;
      checks++;
      if (got[42:40] !== 3'b001) $display("FAIL over_tdi_echo: got %b want 001", got[42:40]);
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b1) $display("FAIL over_ack: got %b want 1", result_ready);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic [79:0] got;
      offer(32'h0000_0077);
      capture();
      shift_n(10, got);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (tdo !== 1'b0) $display("FAIL rstmid_tdo: got %b want 0", tdo);
      else passed++;
      checks++;
      if (result_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", result_ready);
      else passed++;
      update();
      checks++;
      if (tdo !== 1'b0 || result_ready !== 1'b1)
         $display("FAIL rstmid_update: got tdo=%b ready=%b want 0/1", tdo, result_ready);
      else passed++;
      read_frame(got);
      update();
      checks++;
      if (got[39:0] !== 40'h0) $display("FAIL rstmid_frame: got %h want 0", got[39:0]);
      else passed++;
   endtask

   task automatic test_tlr_mid();
      logic [79:0] got;
      offer(32'h0000_0099);
      capture();
      shift_n(10, got);
      test_logic_reset = 1'b1;
      tick();
      test_logic_reset = 1'b0;
      checks++;
      if (tdo !== 1'b0 || result_ready !== 1'b0)
         $display("FAIL tlr_state: got tdo=%b ready=%b want 0/0", tdo, result_ready);
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b0) $display("FAIL tlr_update_ignored: got %b want 0", result_ready);
      else passed++;
      read_frame(got);
      checks++;
      if (got[39:0] !== {32'h0000_0099, 8'h01})
         $display("FAIL tlr_frame: got %h want %h", got[39:0], {32'h0000_0099, 8'h01});
      else passed++;
      update();
      checks++;
      if (result_ready !== 1'b1) $display("FAIL tlr_ack: got %b want 1", result_ready);
      else passed++;
   endtask

   task automatic test_ir_not_user();
      // Shift register now holds the tdi pattern; tdo = pat(0) = 1.
      ir_is_user = 1'b0;
      capture();
      checks++;
      if (tdo !== 1'b1) $display("FAIL ir_capture_ignored: got %b want 1", tdo);
      else passed++;
      ir_is_user = 1'b1;
      capture();
      checks++;
      if (tdo !== 1'b0) $display("FAIL ir_capture_user: got %b want 0", tdo);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_accept_and_read();
      test_empty_read();
      test_partial_read();
      test_late_arrival();
      test_seq_wrap();
      test_overshift();
      test_reset_mid();
      test_tlr_mid();
      test_ir_not_user();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
